// File: rtl/bresenham_pkg.sv
// Shared types and helpers for the Bresenham ray walker.
package bresenham_pkg;

    localparam int unsigned GRID_INDEX_W = 16;

    typedef logic [GRID_INDEX_W-1:0]          index_t;
    typedef logic signed [GRID_INDEX_W:0]     delta_t;
    typedef logic signed [GRID_INDEX_W+1:0]   err_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WALK
    } walker_state_t;

    // Wide enough for any index width the walker is built with.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bresenham_setup.sv
// Combinational per-ray setup terms: deltas, step directions and initial error.
module bresenham_setup
    import bresenham_pkg::*;
#(
    parameter int unsigned INDEX_W = 16
) (
    input  logic [INDEX_W-1:0]        x0,
    input  logic [INDEX_W-1:0]        y0,
    input  logic [INDEX_W-1:0]        x1,
    input  logic [INDEX_W-1:0]        y1,
    output logic signed [INDEX_W:0]   dx,
    output logic signed [INDEX_W:0]   dy,
    output logic                      sx_neg,
    output logic                      sy_neg,
    output logic signed [INDEX_W+1:0] err0
);

    logic [31:0] adx;
    logic [31:0] ady;
    logic        unused_hi;

    always_comb begin
        adx    = abs_diff(32'(x0), 32'(x1));
        ady    = abs_diff(32'(y0), 32'(y1));
        dx     = $signed(adx[INDEX_W:0]);
        dy     = -$signed(ady[INDEX_W:0]);
        sx_neg = !(x1 > x0);
        sy_neg = !(y1 > y0);
        err0   = (INDEX_W+2)'(dx) + (INDEX_W+2)'(dy);
    end

    assign unused_hi = ^{adx[31:INDEX_W+1], ady[31:INDEX_W+1]};

endmodule

// File: rtl/bresenham_ray_walker.sv
// Full-octant streaming Bresenham walker: one cell per handshake, last cell flagged.
// Optional step limit enabled by defining BRESENHAM_MAX_STEPS_EN.
module bresenham_ray_walker
    import bresenham_pkg::*;
#(
    parameter int unsigned INDEX_W   = 16,
    parameter int unsigned MAX_STEPS = 1024,
    parameter int unsigned STEP_W    = $clog2(MAX_STEPS) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INDEX_W-1:0] x0,
    input  logic [INDEX_W-1:0] y0,
    input  logic [INDEX_W-1:0] x1,
    input  logic [INDEX_W-1:0] y1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INDEX_W-1:0] out_x,
    output logic [INDEX_W-1:0] out_y,
    output logic               out_last,
    output logic               out_truncated
);

    walker_state_t state;
    walker_state_t state_next;

    logic [INDEX_W-1:0]        cur_x;
    logic [INDEX_W-1:0]        cur_y;
    logic [INDEX_W-1:0]        end_x;
    logic [INDEX_W-1:0]        end_y;
    logic signed [INDEX_W:0]   dx_r;
    logic signed [INDEX_W:0]   dy_r;
    logic signed [INDEX_W:0]   dx_s;
    logic signed [INDEX_W:0]   dy_s;
    logic                      sx_neg_r;
    logic                      sy_neg_r;
    logic                      sx_neg_s;
    logic                      sy_neg_s;
    logic signed [INDEX_W+1:0] err_r;
    logic signed [INDEX_W+1:0] err0_s;
    logic signed [INDEX_W+1:0] e2;
    logic signed [INDEX_W+1:0] err_next;
    logic                      step_x;
    logic                      step_y;
    logic                      at_end;
    logic                      trunc_hit;
    logic                      fire;

    // cur_* already holds the start cell during SETUP, so it feeds the setup terms.
    bresenham_setup #(
        .INDEX_W(INDEX_W)
    ) u_setup (
        .x0     (cur_x),
        .y0     (cur_y),
        .x1     (end_x),
        .y1     (end_y),
        .dx     (dx_s),
        .dy     (dy_s),
        .sx_neg (sx_neg_s),
        .sy_neg (sy_neg_s),
        .err0   (err0_s)
    );

    assign at_end = (cur_x == end_x) && (cur_y == end_y);
    assign out_x  = cur_x;
    assign out_y  = cur_y;

`ifdef BRESENHAM_MAX_STEPS_EN
    logic [STEP_W-1:0] step_cnt;
    assign trunc_hit = (step_cnt == STEP_W'(MAX_STEPS - 1)) && !at_end;
`else
    logic [STEP_W-1:0] unused_step_limit;
    assign unused_step_limit = STEP_W'(MAX_STEPS - 1);
    assign trunc_hit         = 1'b0;
`endif

    always_comb begin
        e2       = err_r <<< 1;
        step_x   = (e2 >= (INDEX_W+2)'(dy_r));
        step_y   = (e2 <= (INDEX_W+2)'(dx_r));
        err_next = err_r;
        if (step_x) err_next = err_next + (INDEX_W+2)'(dy_r);
        if (step_y) err_next = err_next + (INDEX_W+2)'(dx_r);
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_truncated = 1'b0;
        fire          = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SETUP;
            end
            SETUP: state_next = WALK;
            WALK: begin
                out_valid     = 1'b1;
                out_last      = at_end || trunc_hit;
                out_truncated = trunc_hit;
                fire          = out_ready;
                if (out_ready && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x    <= '0;
            cur_y    <= '0;
            end_x    <= '0;
            end_y    <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            err_r    <= '0;
`ifdef BRESENHAM_MAX_STEPS_EN
            step_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_x <= x0;
                        cur_y <= y0;
                        end_x <= x1;
                        end_y <= y1;
                    end
                end
                SETUP: begin
                    dx_r     <= dx_s;
                    dy_r     <= dy_s;
                    sx_neg_r <= sx_neg_s;
                    sy_neg_r <= sy_neg_s;
                    err_r    <= err0_s;
`ifdef BRESENHAM_MAX_STEPS_EN
                    step_cnt <= '0;
`endif
                end
                WALK: begin
                    if (fire && !out_last) begin
                        err_r <= err_next;
                        if (step_x) cur_x <= sx_neg_r ? cur_x - INDEX_W'(1) : cur_x + INDEX_W'(1);
                        if (step_y) cur_y <= sy_neg_r ? cur_y - INDEX_W'(1) : cur_y + INDEX_W'(1);
`ifdef BRESENHAM_MAX_STEPS_EN
                        step_cnt <= step_cnt + STEP_W'(1);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_ray_walker.sv
// Scoreboard bench for bresenham_ray_walker: directed rays, backpressure, reset mid-ray, random rays.
module tb_bresenham_ray_walker;

    localparam int unsigned INDEX_W = 16;
`ifdef BRESENHAM_MAX_STEPS_EN
    localparam int unsigned MAX_STEPS = 8;
    localparam int          LIMIT     = 8;
`else
    localparam int unsigned MAX_STEPS = 1024;
    localparam int          LIMIT     = 1 << 30;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INDEX_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [INDEX_W-1:0] out_x, out_y;
    logic               out_last, out_truncated;

    always #5 clock = ~clock;

    bresenham_ray_walker #(
        .INDEX_W   (INDEX_W),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .x0            (x0),
        .y0            (y0),
        .x1            (x1),
        .y1            (y1),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_last      (out_last),
        .out_truncated (out_truncated)
    );

    typedef struct {
        int x;
        int y;
        bit last;
        bit trunc;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    beats    = 0;
    bit    ray_done = 1'b0;
    int    rdy_mode = 0;
    int    rdy_cnt  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push_beat(input int x, input int y, input bit last, input bit trunc);
        beat_t b;
        b.x = x; b.y = y; b.last = last; b.trunc = trunc;
        sb.push_back(b);
    endtask

    // Reference Bresenham walk with optional step limit.
    task automatic model_ray(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y;
        bit at_end, tr;
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax1 > ax0) ? 1 : -1;
        sy  = (ay1 > ay0) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        for (int k = 0; k < LIMIT; k++) begin
            at_end = (x == ax1) && (y == ay1);
            tr     = !at_end && (k == LIMIT - 1);
            push_beat(x, y, at_end || tr, tr);
            if (at_end || tr) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    always @(posedge clock) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((rdy_cnt % 3) == 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic [INDEX_W-1:0] px, py;
    logic               pl, pt;
    bit                 stalled = 1'b0;

    always @(negedge clock) begin
        if (reset || !out_valid) begin
            stalled = 1'b0;
        end else begin
            check("walk_in_ready", in_ready, 0);
            if (stalled) begin
                check("hold_x", out_x, px);
                check("hold_y", out_y, py);
                check("hold_last", out_last, pl);
                check("hold_trunc", out_truncated, pt);
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("beat_x", out_x, mon_e.x);
                    check("beat_y", out_y, mon_e.y);
                    check("beat_last", out_last, mon_e.last);
                    check("beat_trunc", out_truncated, mon_e.trunc);
                end
                beats++;
                if (out_last) ray_done = 1'b1;
            end
            stalled = !out_ready;
            px = out_x; py = out_y; pl = out_last; pt = out_truncated;
        end
    end

    task automatic send_ray(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int exp_n, input bit wait_done);
        int budget;
        beats    = 0;
        ray_done = 1'b0;
        @(posedge clock); #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        x0 = INDEX_W'(ax0); y0 = INDEX_W'(ay0);
        x1 = INDEX_W'(ax1); y1 = INDEX_W'(ay1);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        x0 = INDEX_W'($urandom); y0 = INDEX_W'($urandom);
        x1 = INDEX_W'($urandom); y1 = INDEX_W'($urandom);
        check("setup_out_valid", out_valid, 0);
        check("setup_in_ready", in_ready, 0);
        @(posedge clock); #1;
        check("first_valid", out_valid, 1);
        if (!wait_done) return;
        budget = 4 * exp_n + 50;
        while (!ray_done && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        if (!ray_done) begin
            check("ray_timeout", 0, 1);
            sb.delete();
        end else begin
            check("beat_count", beats, exp_n);
            check("sb_left", sb.size(), 0);
        end
    endtask

    function automatic int pick_base();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 65535;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    function automatic int near(input int b);
        int v;
        v = b + int'($urandom_range(0, 40)) - 20;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_trunc", out_truncated, 0);

        // Reset in the middle of a walk discards the ray.
        model_ray(0, 0, 10, 3);
        send_ray(0, 0, 10, 3, sb.size(), 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_x", out_x, 0);
        reset = 1'b0;
        sb.delete();

        push_beat(2, 2, 1, 0);
        send_ray(2, 2, 2, 2, 1, 1'b1);

        push_beat(0, 0, 0, 0); push_beat(1, 0, 0, 0); push_beat(2, 1, 0, 0);
        push_beat(3, 1, 0, 0); push_beat(4, 1, 0, 0); push_beat(5, 2, 0, 0);
        push_beat(6, 2, 1, 0);
        send_ray(0, 0, 6, 2, 7, 1'b1);

        push_beat(5, 5, 0, 0); push_beat(4, 6, 0, 0); push_beat(3, 7, 0, 0);
        push_beat(3, 8, 0, 0); push_beat(2, 9, 1, 0);
        send_ray(5, 5, 2, 9, 5, 1'b1);

        rdy_mode = 1;
        push_beat(3, 3, 0, 0); push_beat(2, 2, 0, 0);
        push_beat(1, 1, 0, 0); push_beat(0, 0, 1, 0);
        send_ray(3, 3, 0, 0, 4, 1'b1);

`ifdef BRESENHAM_MAX_STEPS_EN
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) push_beat(i, 0, i == 7, i == 7);
        send_ray(0, 0, 20, 0, 8, 1'b1);
        for (int i = 0; i < 8; i++) push_beat(i, 0, i == 7, 0);
        send_ray(0, 0, 7, 0, 8, 1'b1);
`endif

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            int rx0, ry0, rx1, ry1, adx, ady, n;
            rx0 = pick_base();
            ry0 = pick_base();
            rx1 = near(rx0);
            ry1 = near(ry0);
            case ($urandom_range(0, 7))
                0:       rx1 = rx0;
                1:       ry1 = ry0;
                default: ;
            endcase
            adx = (rx1 > rx0) ? rx1 - rx0 : rx0 - rx1;
            ady = (ry1 > ry0) ? ry1 - ry0 : ry0 - ry1;
            n   = ((adx > ady) ? adx : ady) + 1;
            if (n > LIMIT) n = LIMIT;
            model_ray(rx0, ry0, rx1, ry1);
            send_ray(rx0, ry0, rx1, ry1, n, 1'b1);
        end

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
